// File: rtl/serial_pattern_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
package serial_pattern_pkg;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic IDLE_LEVEL    = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_pattern_gen.sv
// MSB-first serial transmitter of a latched pattern, with programmable repeats
// separated by a one-cycle idle gap. All outputs come straight from flops.
module serial_pattern_gen
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [LEN_W-1:0] Length,
    input  logic [CNT_W-1:0] Repeat,
    output logic             Serial_Out,
    output logic             Valid,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             serial_q, serial_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_eff;

    // Index is LEN_W wide but the pattern only has WIDTH bits; select explicitly.
    function automatic logic pick_bit(input logic [WIDTH-1:0] pat,
                                      input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (idx == LEN_W'(i)) b = pat[i];
        return b;
    endfunction

    assign len_eff = (Length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : Length;

    // Outputs are computed for the next state so they register alongside it.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rep_d    = rep_q;
        serial_d = IDLE_LEVEL;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    pat_d = Pattern;
                    len_d = len_eff;
                    rep_d = Repeat;
                    if (len_eff == '0) begin
                        idx_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d    = len_eff - LEN_W'(1);
                        state_d  = SHIFT;
                        serial_d = pick_bit(Pattern, len_eff - LEN_W'(1));
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (idx_q == '0) begin
                    if (rep_q != '0) begin
                        rep_d   = rep_q - CNT_W'(1);
                        state_d = GAP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    idx_d    = idx_q - LEN_W'(1);
                    serial_d = pick_bit(pat_q, idx_q - LEN_W'(1));
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            GAP: begin
                idx_d    = len_q - LEN_W'(1);
                state_d  = SHIFT;
                serial_d = pick_bit(pat_q, len_q - LEN_W'(1));
                valid_d  = 1'b1;
                busy_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            serial_q <= IDLE_LEVEL;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rep_q    <= rep_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Serial_Out = serial_q;
    assign Valid      = valid_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule
